sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single Avalon-MM SDRAM controller port between two masters: m0 = VGA
//  framebuffer line fetcher (read-only, high priority), m1 = drawing/cursor master (read/write).
//  Commands are forwarded in the same cycle. A tag FIFO routes pipelined read data back to
//  the issuing master. A starvation counter guarantees that m1 makes progress.
//  Sits between the video/draw masters and the SDRAM controller inside the system top.
// PARAMETERS
//  ADDR_W      25  word address width of the SDRAM port
//  DATA_W      16  data width
//  BE_W        2   byteenable width (DATA_W/8)
//  MAX_PEND    8   max outstanding reads; tag FIFO depth; power of 2, >=2
//  STARVE_MAX  16  cycles m1 may wait while m0 wins before m1 is forced to win once
// PORTS
//  clk_clk            in   1       single clock; all logic on rising edge
//  reset_reset_n      in   1       synchronous, active-low reset
//  m0_address         in   ADDR_W  m0 word address
//  m0_read            in   1       m0 read request
//  m0_waitrequest     out  1       m0 command not accepted this cycle
//  m0_readdata        out  DATA_W  read data (shared bus)
//  m0_readdatavalid   out  1       m0 read data valid
//  m1_address         in   ADDR_W  m1 word address
//  m1_read            in   1       m1 read request
//  m1_write           in   1       m1 write request (never together with m1_read)
//  m1_writedata       in   DATA_W  m1 write data
//  m1_byteenable      in   BE_W    m1 byte enables
//  m1_waitrequest     out  1       m1 command not accepted this cycle
//  m1_readdata        out  DATA_W  read data (shared bus)
//  m1_readdatavalid   out  1       m1 read data valid
//  s_address          out  ADDR_W  to SDRAM ctrl
//  s_read/s_write     out  1       to SDRAM ctrl
//  s_writedata        out  DATA_W  to SDRAM ctrl
//  s_byteenable       out  BE_W    to SDRAM ctrl; all-ones for m0 reads
//  s_waitrequest      in   1       from SDRAM ctrl
//  s_readdata         in   DATA_W  from SDRAM ctrl
//  s_readdatavalid    in   1       from SDRAM ctrl
//  pend_count         out  log2(MAX_PEND)+1  outstanding reads
//  err_sticky         out  1       readdatavalid seen with tag FIFO empty; cleared only by reset
// BEHAVIOUR
//  Reset (reset_reset_n=0 at an edge):
//   - Clears grant lock, starve counter, FIFO pointers, pend_count and err_sticky.
//   - While reset is low, combinationally forces s_read=s_write=0, m*_waitrequest=1, m*_readdatavalid=0.
//  Accept: a command is accepted when (s_read|s_write) & !s_waitrequest. Accepted = grant.
//  States: IDLE / LOCKED.
//   - IDLE: the winner is chosen combinationally. m0 wins if it requests, unless starve_hit.
//   - A command presented with s_waitrequest=1 -> LOCKED on that grant. The s_* outputs stay
//     sourced from the same master until accept, then -> IDLE.
//  Read gating: a read is not presented to s_* while pend_count==MAX_PEND; its master sees
//   waitrequest=1. In IDLE, a blocked read loses to the other master's eligible request.
//   Writes are never gated by FIFO full.
//  mN_waitrequest = !(grantN & presented) | s_waitrequest. A non-granted requester sees 1.
//  Starvation: starve_cnt increments each cycle m1 requests and m0 is accepted.
//   - Saturates at STARVE_MAX; starve_hit = (starve_cnt==STARVE_MAX).
//   - Clears to 0 when m1 is accepted.
//  Tag FIFO: push the grant ID on each accepted read; pop on s_readdatavalid.
//   - The popped ID selects m0_ or m1_readdatavalid in the same cycle (0-cycle latency).
//   - readdata is s_readdata, passed straight to both masters.
//   - Push and pop in the same cycle: pend_count unchanged; the FIFO wraps modulo MAX_PEND.
//   - s_readdatavalid with an empty FIFO: no valid forwarded, err_sticky<=1, count stays 0.
//  Order: read data returns in issue order; the controller guarantees in-order returns.
// TESTING
//  1 Reset: hold reset_reset_n=0 with m0_read=m1_write=1 -> s_read=s_write=0,
//    both waitrequest=1, pend_count=0.
//  2 Priority: m0_read and m1_write both asserted, s_waitrequest=0 -> m0 accepted every cycle.
//    On cycle STARVE_MAX+1 (17), m1 is accepted instead; starve_cnt returns to 0.
//  3 Lock: m1_write presented, s_waitrequest=1 for 3 cycles while m0_read rises -> s_* hold
//    m1 values; m1 is accepted on cycle 4; m0 is accepted on cycle 5.
//  4 Full: 8 m0 reads accepted, no readdatavalid -> pend_count=8 and m0_waitrequest=1.
//    An m1_write is still accepted. One readdatavalid with m0_read held -> that read is
//    accepted in the same cycle and pend_count stays 8.
//  5 Routing: reads issued m0,m1,m0 with returns A,B,C -> m0_readdatavalid on A and C,
//    m1_readdatavalid on B, pend_count 3->0.
//  6 Error: s_readdatavalid=1 while pend_count=0 -> no master valid, err_sticky=1 until reset.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter in front of a single Avalon-MM SDRAM controller port.
// m0 (video fetch) has priority; m1 is guaranteed progress by a starvation counter.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int BE_W       = 2,
  parameter int MAX_PEND   = 8,
  parameter int STARVE_MAX = 16,
  localparam int PW        = $clog2(MAX_PEND) + 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic [PW-1:0]     pend_count,
  output logic              err_sticky
);

  localparam int AW = $clog2(MAX_PEND);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [PW-1:0] PEND_LIM   = PW'(MAX_PEND);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic            lock_id_q, lock_id_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            err_q, err_d;
  logic [MAX_PEND-1:0] tag_q, tag_d;

  logic grant, presented, accept, pop, push, full;
  logic m0_elig, m1_elig, m1_req, starve_hit, rd_cmd, wr_cmd;

  // A pop in the same cycle frees a slot, so a full FIFO does not block a read then.
  always_comb begin
    m1_req     = m1_read | m1_write;
    pop        = s_readdatavalid & (pend_q != '0);
    full       = (pend_q == PEND_LIM) & ~pop;
    m0_elig    = m0_read & ~full;
    m1_elig    = m1_write | (m1_read & ~full);
    starve_hit = (starve_q == STARVE_LIM);

    grant     = 1'b0;
    presented = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_elig && !(starve_hit && m1_elig)) begin
          grant     = 1'b0;
          presented = 1'b1;
        end else if (m1_elig) begin
          grant     = 1'b1;
          presented = 1'b1;
        end
      end
      LOCKED: begin
        grant     = lock_id_q;
        presented = lock_id_q ? m1_elig : m0_elig;
      end
      default: ;
    endcase
    if (!reset_reset_n) presented = 1'b0;

    rd_cmd = presented & (grant ? m1_read : m0_read);
    wr_cmd = presented & grant & m1_write;
    accept = presented & ~s_waitrequest;
    push   = accept & rd_cmd;
  end

  always_comb begin
    s_address    = grant ? m1_address : m0_address;
    s_read       = rd_cmd;
    s_write      = wr_cmd;
    s_writedata  = grant ? m1_writedata : '0;
    s_byteenable = grant ? m1_byteenable : '1;

    m0_waitrequest = !(presented && !grant) || s_waitrequest;
    m1_waitrequest = !(presented && grant) || s_waitrequest;

    m0_readdata      = s_readdata;
    m1_readdata      = s_readdata;
    m0_readdatavalid = reset_reset_n & pop & ~tag_q[rd_ptr_q];
    m1_readdatavalid = reset_reset_n & pop &  tag_q[rd_ptr_q];

    pend_count = pend_q;
    err_sticky = err_q;
  end

  always_comb begin
    state_d   = (presented && s_waitrequest) ? LOCKED : IDLE;
    lock_id_d = (presented && s_waitrequest) ? grant : lock_id_q;

    starve_d = starve_q;
    if (accept && grant)
      starve_d = '0;
    else if (accept && !grant && m1_req && !starve_hit)
      starve_d = starve_q + 1'b1;

    tag_d = tag_q;
    if (push) tag_d[wr_ptr_q] = grant;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    pend_d   = pend_q + PW'(push) - PW'(pop);
    err_d    = err_q | (s_readdatavalid & (pend_q == '0));
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      lock_id_q <= 1'b0;
      starve_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pend_q    <= '0;
      err_q     <= 1'b0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      starve_q  <= starve_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      tag_q     <= tag_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: idle-arbitration vector table, directed corner
// sequences, then randomized traffic checked against a queue-based model.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 25, DATA_W = 16, BE_W = 2, MAX_PEND = 8, STARVE_MAX = 16;
  localparam int PW = $clog2(MAX_PEND) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_waitrequest, m0_readdatavalid;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, m1_writedata, s_writedata, s_readdata;
  logic              m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
  logic [BE_W-1:0]   m1_byteenable, s_byteenable;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [PW-1:0]     pend_count;
  logic              err_sticky;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
                       .MAX_PEND(MAX_PEND), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .pend_count(pend_count), .err_sticky(err_sticky)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic m0r, m1r, m1w, sw;
    logic e_rd, e_wr, e_m1src, e_m0w, e_m1w;
  } vec_t;
  vec_t vecs[8];

  // reference model state
  int  mq[$];
  int  m_starve;
  bit  m_locked, m_lock_id, m_err;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    m0_address = 25'h1111; m1_address = 25'h2222;
    m1_writedata = 16'hbeef; m1_byteenable = 2'b01;
    idle_inputs();

    // reset holds everything quiet even with requests pending
    rst_n = 1'b0;
    m0_read = 1'b1; m1_write = 1'b1;
    tick(); tick();
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_pend", pend_count, 0);
    chk("rst_err", err_sticky, 0);

    // idle arbitration table, each vector from a fresh reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      m0_read = vecs[i].m0r; m1_read = vecs[i].m1r; m1_write = vecs[i].m1w;
      s_waitrequest = vecs[i].sw;
      #1;
      chk($sformatf("vec%0d_s_read", i), s_read, vecs[i].e_rd);
      chk($sformatf("vec%0d_s_write", i), s_write, vecs[i].e_wr);
      chk($sformatf("vec%0d_m0_wait", i), m0_waitrequest, vecs[i].e_m0w);
      chk($sformatf("vec%0d_m1_wait", i), m1_waitrequest, vecs[i].e_m1w);
      chk($sformatf("vec%0d_addr", i), s_address, vecs[i].e_m1src ? 32'h2222 : 32'h1111);
      chk($sformatf("vec%0d_be", i), s_byteenable, vecs[i].e_m1src ? 32'h1 : 32'h3);
    end

    // priority + starvation: m1 gets the 17th slot, then m0 again
    do_reset();
    m0_read = 1'b1; m1_write = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      s_readdatavalid = (c >= 2 && c <= 17);
      #1;
      if (c == 17) begin
        chk("starve_s_write", s_write, 1);
        chk("starve_s_read", s_read, 0);
        chk("starve_m1_wait", m1_waitrequest, 0);
        chk("starve_m0_wait", m0_waitrequest, 1);
        chk("starve_wdata", s_writedata, 16'hbeef);
      end else begin
        chk($sformatf("prio_c%0d_s_read", c), s_read, 1);
        chk($sformatf("prio_c%0d_m0_wait", c), m0_waitrequest, 0);
        chk($sformatf("prio_c%0d_m1_wait", c), m1_waitrequest, 1);
      end
      if (s_readdatavalid) chk($sformatf("prio_c%0d_rdv", c), m0_readdatavalid, 1);
      tick();
    end

    // lock: m1 write stalls 3 cycles while m0 starts requesting
    do_reset();
    m1_write = 1'b1; s_waitrequest = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c >= 2) m0_read = 1'b1;
      if (c == 4) s_waitrequest = 1'b0;
      #1;
      chk($sformatf("lock_c%0d_s_write", c), s_write, 1);
      chk($sformatf("lock_c%0d_s_read", c), s_read, 0);
      chk($sformatf("lock_c%0d_addr", c), s_address, 32'h2222);
      chk($sformatf("lock_c%0d_m0_wait", c), m0_waitrequest, 1);
      chk($sformatf("lock_c%0d_m1_wait", c), m1_waitrequest, (c == 4) ? 0 : 1);
      tick();
    end
    m1_write = 1'b0;
    #1;
    chk("lock_c5_s_read", s_read, 1);
    chk("lock_c5_m0_wait", m0_waitrequest, 0);
    chk("lock_c5_addr", s_address, 32'h1111);
    tick();

    // full FIFO: reads block, writes pass, a pop lets a read through same cycle
    do_reset();
    m0_read = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("full_fill%0d", c), m0_waitrequest, 0);
      tick();
    end
    chk("full_pend8", pend_count, 8);
    chk("full_m0_wait", m0_waitrequest, 1);
    chk("full_s_read", s_read, 0);
    m1_write = 1'b1;
    #1;
    chk("full_wr_s_write", s_write, 1);
    chk("full_wr_m1_wait", m1_waitrequest, 0);
    tick();
    chk("full_wr_pend", pend_count, 8);
    m1_write = 1'b0; s_readdatavalid = 1'b1;
    #1;
    chk("full_pop_s_read", s_read, 1);
    chk("full_pop_m0_wait", m0_waitrequest, 0);
    chk("full_pop_rdv", m0_readdatavalid, 1);
    tick();
    s_readdatavalid = 1'b0; m0_read = 1'b0;
    chk("full_pop_pend", pend_count, 8);

    // routing m0,m1,m0
    do_reset();
    m0_read = 1'b1; tick();
    m0_read = 1'b0; m1_read = 1'b1; tick();
    m1_read = 1'b0; m0_read = 1'b1; tick();
    m0_read = 1'b0;
    chk("route_pend3", pend_count, 3);
    s_readdatavalid = 1'b1;
    s_readdata = 16'haaaa; #1;
    chk("route_A_m0", m0_readdatavalid, 1); chk("route_A_m1", m1_readdatavalid, 0);
    chk("route_A_data", m0_readdata, 16'haaaa);
    tick();
    s_readdata = 16'hbbbb; #1;
    chk("route_B_m0", m0_readdatavalid, 0); chk("route_B_m1", m1_readdatavalid, 1);
    chk("route_B_data", m1_readdata, 16'hbbbb);
    tick();
    s_readdata = 16'hcccc; #1;
    chk("route_C_m0", m0_readdatavalid, 1); chk("route_C_m1", m1_readdatavalid, 0);
    tick();
    s_readdatavalid = 1'b0;
    chk("route_pend0", pend_count, 0);

    // spurious return
    do_reset();
    s_readdatavalid = 1'b1; #1;
    chk("err_m0_rdv", m0_readdatavalid, 0);
    chk("err_m1_rdv", m1_readdatavalid, 0);
    tick();
    s_readdatavalid = 1'b0;
    chk("err_set", err_sticky, 1);
    chk("err_pend", pend_count, 0);
    tick(); tick();
    chk("err_hold", err_sticky, 1);
    do_reset();
    chk("err_clr", err_sticky, 0);

    // randomized traffic vs. model; masters hold a command until accepted
    begin
      bit h0 = 0, h1 = 0;
      mq.delete(); m_starve = 0; m_locked = 0; m_lock_id = 0; m_err = 0;
      for (int c = 0; c < 1500; c++) begin
        bit pop, full, e0, e1, g, pres, erd, ewr, acc, was_empty;
        int k;
        if (!h0) begin
          h0 = ($urandom_range(0, 2) != 0);
          m0_address = ADDR_W'($urandom);
        end
        if (!h1) begin
          k = $urandom_range(0, 3);
          m1_read = (k == 1); m1_write = (k >= 2); h1 = (k != 0);
          m1_address = ADDR_W'($urandom);
          m1_writedata = DATA_W'($urandom);
          m1_byteenable = BE_W'($urandom);
        end
        m0_read = h0;
        s_waitrequest = ($urandom_range(0, 3) == 0);
        s_readdatavalid = ($urandom_range(0, 1) == 0) &&
                          (mq.size() > 0 || $urandom_range(0, 60) == 0);
        s_readdata = DATA_W'($urandom);
        #1;
        was_empty = (mq.size() == 0);
        pop  = s_readdatavalid && !was_empty;
        full = (mq.size() == MAX_PEND) && !pop;
        e0 = m0_read && !full;
        e1 = m1_write || (m1_read && !full);
        g = 0; pres = 0;
        if (m_locked) begin
          g = m_lock_id; pres = g ? e1 : e0;
        end else if (e0 && !(m_starve == STARVE_MAX && e1)) begin
          g = 0; pres = 1;
        end else if (e1) begin
          g = 1; pres = 1;
        end
        erd = pres && (g ? m1_read : m0_read);
        ewr = pres && g && m1_write;
        chk("rnd_s_read", s_read, erd);
        chk("rnd_s_write", s_write, ewr);
        if (pres) chk("rnd_addr", s_address, g ? m1_address : m0_address);
        if (pres && !g) chk("rnd_be", s_byteenable, 2'b11);
        chk("rnd_m0_wait", m0_waitrequest, !(pres && !g) || s_waitrequest);
        chk("rnd_m1_wait", m1_waitrequest, !(pres && g) || s_waitrequest);
        chk("rnd_m0_rdv", m0_readdatavalid, pop && mq[0] == 0);
        chk("rnd_m1_rdv", m1_readdatavalid, pop && mq[0] == 1);
        chk("rnd_rdata", m0_readdata, s_readdata);
        chk("rnd_pend", pend_count, mq.size());
        chk("rnd_err", err_sticky, m_err);
        acc = pres && !s_waitrequest;
        tick();
        if (pop) void'(mq.pop_front());
        if (acc && erd) mq.push_back(int'(g));
        if (s_readdatavalid && was_empty) m_err = 1;
        if (acc && g) m_starve = 0;
        else if (acc && !g && (m1_read || m1_write) && m_starve < STARVE_MAX) m_starve++;
        m_locked = pres && s_waitrequest;
        m_lock_id = g;
        if (acc && !g) h0 = 0;
        if (acc && g) h1 = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
